// File: rtl/scope_trace_writer.sv
// Writer side of the 320x240 video memory: draws one oscilloscope column
// per sample and sweeps the frame to background on reset or request.
module scope_trace_writer #(
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter logic [2:0] TRACE_COLOUR = 3'b010,
    parameter int         H_DOTS       = 320,
    parameter int         V_DOTS       = 240
) (
    input  logic        vga_clock,
    input  logic        resetn,
    input  logic        clear_req,
    input  logic        sample_valid,
    input  logic [7:0]  sample,
    output logic        sample_ready,
    output logic        wr_en,
    output logic [16:0] wr_address,
    output logic [2:0]  wr_colour,
    output logic        busy,
    output logic [8:0]  column
);

    localparam logic [16:0] LAST_ADDR = 17'(H_DOTS * V_DOTS - 1);
    localparam logic [7:0]  LAST_ROW  = 8'(V_DOTS - 1);
    localparam logic [8:0]  LAST_COL  = 9'(H_DOTS - 1);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ERASE,
        DRAW,
        ADVANCE
    } state_t;

    state_t      state, state_n;
    logic [16:0] count, count_n;
    logic [8:0]  x, x_n;
    logic [7:0]  y_new, y_new_n;
    logic [7:0]  prev_y, prev_y_n;
    logic [7:0]  lo, lo_n;
    logic [7:0]  hi, hi_n;
    logic        prev_valid, prev_valid_n;
    logic        clear_pending, clear_pending_n;
    logic [8:0]  column_n;
    logic        wr_en_n;
    logic [16:0] wr_address_n;
    logic [2:0]  wr_colour_n;
    logic        sample_ready_n;
    logic        busy_n;

    logic [11:0] scaled;
    logic [7:0]  y_sample;
    logic [7:0]  seg_lo;
    logic [7:0]  seg_hi;
    logic [7:0]  row;
    logic        accept;

    function automatic logic [16:0] pixel_addr(input logic [8:0] px,
                                               input logic [7:0] py);
        return {1'b0, py, 8'b0} + {3'b0, py, 6'b0} + {8'b0, px};
    endfunction

    // Sample 0 is the bottom row, 255 the top row.
    assign scaled   = {4'b0, sample} * 12'd15;
    assign y_sample = LAST_ROW - 8'(scaled >> 4);

    assign seg_lo = (!prev_valid || y_sample < prev_y) ? y_sample : prev_y;
    assign seg_hi = (!prev_valid || y_sample > prev_y) ? y_sample : prev_y;

    assign row    = count[7:0];
    assign accept = sample_valid && sample_ready;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state         <= CLEAR;
            count         <= '0;
            x             <= '0;
            y_new         <= '0;
            prev_y        <= '0;
            lo            <= '0;
            hi            <= '0;
            prev_valid    <= 1'b0;
            clear_pending <= 1'b0;
            column        <= '0;
            wr_en         <= 1'b0;
            wr_address    <= '0;
            wr_colour     <= '0;
            sample_ready  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            x             <= x_n;
            y_new         <= y_new_n;
            prev_y        <= prev_y_n;
            lo            <= lo_n;
            hi            <= hi_n;
            prev_valid    <= prev_valid_n;
            clear_pending <= clear_pending_n;
            column        <= column_n;
            wr_en         <= wr_en_n;
            wr_address    <= wr_address_n;
            wr_colour     <= wr_colour_n;
            sample_ready  <= sample_ready_n;
            busy          <= busy_n;
        end
    end

    // Outputs are computed for the cycle after the edge, so each state
    // issues the write that the registered outputs present next.
    always_comb begin
        state_n         = state;
        count_n         = count;
        x_n             = x;
        y_new_n         = y_new;
        prev_y_n        = prev_y;
        lo_n            = lo;
        hi_n            = hi;
        prev_valid_n    = prev_valid;
        clear_pending_n = clear_pending | clear_req;
        column_n        = column;
        wr_en_n         = 1'b0;
        wr_address_n    = wr_address;
        wr_colour_n     = wr_colour;
        sample_ready_n  = 1'b0;
        busy_n          = 1'b1;

        unique case (state)
            CLEAR: begin
                wr_en_n      = 1'b1;
                wr_address_n = count;
                wr_colour_n  = BG_COLOUR;
                if (count == LAST_ADDR) begin
                    state_n         = IDLE;
                    count_n         = '0;
                    column_n        = '0;
                    prev_valid_n    = 1'b0;
                    clear_pending_n = 1'b0;
                end else begin
                    count_n = count + 17'd1;
                end
            end
            IDLE: begin
                if (clear_pending || clear_req) begin
                    state_n         = CLEAR;
                    wr_en_n         = 1'b1;
                    wr_address_n    = '0;
                    wr_colour_n     = BG_COLOUR;
                    count_n         = 17'd1;
                    clear_pending_n = 1'b0;
                end else if (accept) begin
                    state_n      = ERASE;
                    x_n          = column;
                    y_new_n      = y_sample;
                    lo_n         = seg_lo;
                    hi_n         = seg_hi;
                    wr_en_n      = 1'b1;
                    wr_address_n = pixel_addr(column, 8'd0);
                    wr_colour_n  = BG_COLOUR;
                    count_n      = 17'd1;
                end else begin
                    sample_ready_n = 1'b1;
                    busy_n         = 1'b0;
                end
            end
            ERASE: begin
                wr_en_n      = 1'b1;
                wr_address_n = pixel_addr(x, row);
                wr_colour_n  = BG_COLOUR;
                if (row == LAST_ROW) begin
                    state_n = DRAW;
                    count_n = {9'b0, lo};
                end else begin
                    count_n = count + 17'd1;
                end
            end
            DRAW: begin
                wr_en_n      = 1'b1;
                wr_address_n = pixel_addr(x, row);
                wr_colour_n  = TRACE_COLOUR;
                if (row == hi) begin
                    state_n = ADVANCE;
                end else begin
                    count_n = count + 17'd1;
                end
            end
            ADVANCE: begin
                state_n      = IDLE;
                count_n      = '0;
                prev_y_n     = y_new;
                prev_valid_n = 1'b1;
                column_n     = (x == LAST_COL) ? 9'd0 : x + 9'd1;
            end
            default: begin
                state_n = CLEAR;
                count_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_scope_trace_writer.sv
// Directed bench for scope_trace_writer: frame clear, column drawing,
// wrap, clear requests and asynchronous reset.
module tb_scope_trace_writer;

    logic        vga_clock = 1'b0;
    logic        resetn = 1'b0;
    logic        clear_req = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample = 8'd0;
    logic        sample_ready;
    logic        wr_en;
    logic [16:0] wr_address;
    logic [2:0]  wr_colour;
    logic        busy;
    logic [8:0]  column;

    int n_checks = 0;
    int n_fail = 0;

    logic [16:0] cap_addr[$];
    logic [2:0]  cap_col[$];

    always #5 vga_clock = ~vga_clock;

    scope_trace_writer dut (
        .vga_clock    (vga_clock),
        .resetn       (resetn),
        .clear_req    (clear_req),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (sample_ready),
        .wr_en        (wr_en),
        .wr_address   (wr_address),
        .wr_colour    (wr_colour),
        .busy         (busy),
        .column       (column)
    );

    // Counts mismatches between the captured writes and one column's
    // erase (rows 0..239, colour 000) followed by a trace lo..hi (010).
    function automatic int column_errs(input int cx, input int lo, input int hi);
        int e;
        e = 0;
        if (cap_addr.size() != 240 + hi - lo + 1) return -1;
        for (int r = 0; r < 240; r++)
            if (cap_addr[r] !== 17'(r * 320 + cx) || cap_col[r] !== 3'b000) e++;
        for (int r = lo; r <= hi; r++)
            if (cap_addr[240 + r - lo] !== 17'(r * 320 + cx) ||
                cap_col[240 + r - lo] !== 3'b010) e++;
        return e;
    endfunction

    // Offers one sample at a negedge and records writes until ready returns.
    task automatic run_sample(input logic [7:0] s, output int lat);
        cap_addr.delete();
        cap_col.delete();
        lat = -1;
        sample = s;
        sample_valid = 1'b1;
        @(negedge vga_clock);
        sample_valid = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (wr_en) begin
                cap_addr.push_back(wr_address);
                cap_col.push_back(wr_colour);
            end
            if (sample_ready) begin
                lat = k;
                break;
            end
            @(negedge vga_clock);
        end
    endtask

    // Follows a frame sweep from the current negedge to the first idle cycle.
    task automatic sweep(output int writes, output int errs);
        writes = 0;
        errs = 0;
        for (int k = 0; k < 80000; k++) begin
            if (wr_en) begin
                if (wr_address !== 17'(writes) || wr_colour !== 3'b000 ||
                    sample_ready !== 1'b0 || busy !== 1'b1) errs++;
                writes++;
            end else if (writes > 0) begin
                break;
            end
            @(negedge vga_clock);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge vga_clock);
        n_checks++;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_checks++;
        if (wr_address !== 17'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", wr_address); end
        n_checks++;
        if (wr_colour !== 3'b000) begin n_fail++; $display("FAIL reset_colour got %b want 000", wr_colour); end
        n_checks++;
        if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", sample_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (column !== 9'd0) begin n_fail++; $display("FAIL reset_column got %0d want 0", column); end
    endtask

    task automatic test_power_up_clear;
        int w, e;
        resetn = 1'b1;
        sweep(w, e);
        n_checks++;
        if (w != 76800) begin n_fail++; $display("FAIL clear_count got %0d want 76800", w); end
        n_checks++;
        if (e != 0) begin n_fail++; $display("FAIL clear_sequence got %0d bad writes want 0", e); end
        n_checks++;
        if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready got %b want 1", sample_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", busy); end
        n_checks++;
        if (column !== 9'd0) begin n_fail++; $display("FAIL clear_column got %0d want 0", column); end
    endtask

    task automatic test_first_sample;
        int lat, e;
        run_sample(8'd128, lat);
        e = column_errs(0, 119, 119);
        n_checks++;
        if (e != 0) begin n_fail++; $display("FAIL mid_writes got %0d errs (n=%0d) want 0", e, cap_addr.size()); end
        n_checks++;
        if (cap_addr.size() != 241 || cap_addr[240] !== 17'd38080)
            begin n_fail++; $display("FAIL mid_pixel got n=%0d want pixel at 38080", cap_addr.size()); end
        n_checks++;
        if (lat != 242) begin n_fail++; $display("FAIL mid_latency got %0d want 242", lat); end
        n_checks++;
        if (column !== 9'd1) begin n_fail++; $display("FAIL mid_column got %0d want 1", column); end
    endtask

    task automatic test_second_sample;
        int lat, e;
        run_sample(8'd255, lat);
        e = column_errs(1, 0, 119);
        n_checks++;
        if (e != 0) begin n_fail++; $display("FAIL top_writes got %0d errs (n=%0d) want 0", e, cap_addr.size()); end
        n_checks++;
        if (lat != 361) begin n_fail++; $display("FAIL top_latency got %0d want 361", lat); end
        n_checks++;
        if (column !== 9'd2) begin n_fail++; $display("FAIL top_column got %0d want 2", column); end
    endtask

    task automatic test_wrap;
        int lat, bad, lo, e;
        bad = 0;
        for (int c = 2; c < 320; c++) begin
            lo = (c == 2) ? 0 : 239;
            run_sample(8'd0, lat);
            if (column_errs(c, lo, 239) != 0 || lat != 242 + 239 - lo) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL wrap_columns got %0d bad columns want 0", bad); end
        n_checks++;
        if (column !== 9'd0) begin n_fail++; $display("FAIL wrap_column got %0d want 0", column); end
        run_sample(8'd0, lat);
        n_checks++;
        if (cap_addr.size() != 241 || cap_addr[240] !== 17'd76480 || cap_col[240] !== 3'b010)
            begin n_fail++; $display("FAIL wrap_pixel got n=%0d want one pixel at 76480", cap_addr.size()); end
        run_sample(8'd128, lat);
        e = column_errs(1, 119, 239);
        n_checks++;
        if (e != 0 || lat != 362) begin n_fail++; $display("FAIL wrap_link got errs=%0d lat=%0d want 0/362", e, lat); end
        n_checks++;
        if (column !== 9'd2) begin n_fail++; $display("FAIL wrap_next_column got %0d want 2", column); end
    endtask

    task automatic test_clear_during_draw;
        int w, e, lat;
        cap_addr.delete();
        cap_col.delete();
        sample = 8'd255;
        sample_valid = 1'b1;
        @(negedge vga_clock);
        sample_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            clear_req = (k == 250);
            if (!wr_en) break;
            cap_addr.push_back(wr_address);
            cap_col.push_back(wr_colour);
            @(negedge vga_clock);
        end
        clear_req = 1'b0;
        e = column_errs(2, 0, 119);
        n_checks++;
        if (e != 0) begin n_fail++; $display("FAIL cdraw_column got %0d errs (n=%0d) want 0", e, cap_addr.size()); end
        n_checks++;
        if (sample_ready !== 1'b0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL cdraw_advance got ready=%b busy=%b want 0/1", sample_ready, busy); end
        n_checks++;
        if (column !== 9'd3) begin n_fail++; $display("FAIL cdraw_adv_column got %0d want 3", column); end
        sample = 8'd64;
        sample_valid = 1'b1;
        @(negedge vga_clock);
        sample_valid = 1'b0;
        n_checks++;
        if (wr_en !== 1'b1 || wr_address !== 17'd0 || sample_ready !== 1'b0)
            begin n_fail++; $display("FAIL cdraw_enter_clear got en=%b addr=%0d ready=%b want 1/0/0",
                                     wr_en, wr_address, sample_ready); end
        sweep(w, e);
        n_checks++;
        if (w != 76800 || e != 0) begin n_fail++; $display("FAIL cdraw_sweep got n=%0d errs=%0d want 76800/0", w, e); end
        n_checks++;
        if (column !== 9'd0 || sample_ready !== 1'b1)
            begin n_fail++; $display("FAIL cdraw_after got column=%0d ready=%b want 0/1", column, sample_ready); end
        run_sample(8'd200, lat);
        e = column_errs(0, 52, 52);
        n_checks++;
        if (e != 0 || lat != 242) begin n_fail++; $display("FAIL cdraw_single got errs=%0d lat=%0d want 0/242", e, lat); end
    endtask

    task automatic test_clear_priority;
        int w, e;
        clear_req = 1'b1;
        sample_valid = 1'b1;
        sample = 8'd64;
        @(negedge vga_clock);
        clear_req = 1'b0;
        sample_valid = 1'b0;
        n_checks++;
        if (wr_en !== 1'b1 || wr_address !== 17'd0 || wr_colour !== 3'b000)
            begin n_fail++; $display("FAIL prio_start got en=%b addr=%0d col=%b want 1/0/000",
                                     wr_en, wr_address, wr_colour); end
        n_checks++;
        if (sample_ready !== 1'b0 || column !== 9'd1)
            begin n_fail++; $display("FAIL prio_no_accept got ready=%b column=%0d want 0/1", sample_ready, column); end
        sweep(w, e);
        n_checks++;
        if (w != 76800 || e != 0) begin n_fail++; $display("FAIL prio_sweep got n=%0d errs=%0d want 76800/0", w, e); end
        n_checks++;
        if (column !== 9'd0 || sample_ready !== 1'b1)
            begin n_fail++; $display("FAIL prio_after got column=%0d ready=%b want 0/1", column, sample_ready); end
    endtask

    task automatic test_reset_in_erase;
        int w, e;
        sample = 8'd128;
        sample_valid = 1'b1;
        @(negedge vga_clock);
        sample_valid = 1'b0;
        repeat (20) @(negedge vga_clock);
        n_checks++;
        if (wr_en !== 1'b1 || wr_address !== 17'd6400)
            begin n_fail++; $display("FAIL rst_erasing got en=%b addr=%0d want 1/6400", wr_en, wr_address); end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_address !== 17'd0 || busy !== 1'b0 || column !== 9'd0)
            begin n_fail++; $display("FAIL rst_async got en=%b addr=%0d busy=%b column=%0d want 0/0/0/0",
                                     wr_en, wr_address, busy, column); end
        @(negedge vga_clock);
        resetn = 1'b1;
        w = 0;
        e = 0;
        for (int k = 0; k < 200 && w < 100; k++) begin
            @(negedge vga_clock);
            if (wr_en) begin
                if (wr_address !== 17'(w) || wr_colour !== 3'b000 || busy !== 1'b1) e++;
                w++;
            end
        end
        n_checks++;
        if (w != 100 || e != 0) begin n_fail++; $display("FAIL rst_reclear got n=%0d errs=%0d want 100/0", w, e); end
    endtask

    initial begin
        test_reset();
        test_power_up_clear();
        test_first_sample();
        test_second_sample();
        test_wrap();
        test_clear_during_draw();
        test_clear_priority();
        test_reset_in_erase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
